// File: rtl/mem_ctrl_mp.sv
// mem_ctrl_mp: multi-port byte-serial memory controller.
//   Arbitrates NPORT requesters onto a single 8-bit RAM port and turns each
//   byte/half/word access into N byte cycles (little-endian).
//   The RAM returns read data two edges after its address is driven.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   req_*          per-port request bundles, port p in slice p
//   ram_*          byte-wide RAM interface
//   done           one-cycle completion pulse, one bit per port
//   rdata          last completed read, extended to 32 bits
//   busy           transaction in progress
module mem_ctrl_mp #(
  parameter int NPORT  = 2,
  parameter int ADDR_W = 17,
  parameter int RR_EN  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORT-1:0]        req_valid,
  input  logic [NPORT-1:0]        req_we,
  input  logic [2*NPORT-1:0]      req_size,
  input  logic [NPORT-1:0]        req_sext,
  input  logic [ADDR_W*NPORT-1:0] req_addr,
  input  logic [32*NPORT-1:0]     req_wdata,
  input  logic [7:0]              ram_din,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [7:0]              ram_dout,
  output logic [NPORT-1:0]        done,
  output logic [31:0]             rdata,
  output logic                    busy
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     last_grant, gnt, sel;
  logic              sel_vld;
  logic [ADDR_W-1:0] la;        // latched start address
  logic [2:0]        len;       // latched byte count N
  logic [2:0]        cnt;       // edges since accept, minus one
  logic              sext;
  logic [31:0]       wdat;
  logic [23:0]       res;       // bytes captured before the final one
  logic [ADDR_W-1:0] sel_addr, cur_addr;
  logic [1:0]        sel_size;
  logic [2:0]        sel_len;
  logic              cur_valid;
  logic [31:0]       rd_ext;

  // Arbiter: scan from last_grant+1 (round-robin) or from port 0 (fixed).
  always_comb begin
    int idx;
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < NPORT; i++) begin
      idx = (RR_EN != 0) ? int'(last_grant) + 1 + i : i;
      if (idx >= NPORT) idx = idx - NPORT;
      if (!sel_vld && req_valid[PW'(idx)]) begin
        sel_vld = 1'b1;
        sel     = PW'(idx);
      end
    end
  end

  assign sel_addr  = req_addr[int'(sel)*ADDR_W +: ADDR_W];
  assign sel_size  = req_size[int'(sel)*2 +: 2];
  assign cur_addr  = req_addr[int'(gnt)*ADDR_W +: ADDR_W];
  assign cur_valid = req_valid[gnt];
  assign busy      = (state != IDLE);

  always_comb begin
    case (sel_size)
      2'd0:    sel_len = 3'd1;
      2'd1:    sel_len = 3'd2;
      default: sel_len = 3'd4;
    endcase
  end

  // Final read byte arrives in the completion cycle; merge it directly.
  always_comb begin
    case (len)
      3'd1:    rd_ext = sext ? {{24{ram_din[7]}}, ram_din} : {24'h0, ram_din};
      3'd2:    rd_ext = sext ? {{16{ram_din[7]}}, ram_din, res[7:0]}
                             : {16'h0, ram_din, res[7:0]};
      default: rd_ext = {ram_din, res[23:0]};
    endcase
  end

  // Next state. A read aborts if its requester drops valid or moves its
  // address before the completion edge; writes always run to completion.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (sel_vld) state_nx = req_we[sel] ? WR : RD;
      RD: begin
        if (cnt == len)                          state_nx = IDLE;
        else if (!cur_valid || cur_addr != la)   state_nx = IDLE;
      end
      WR:      if (cnt == len) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= PW'(NPORT - 1);
      gnt        <= '0;
      la         <= '0;
      len        <= '0;
      cnt        <= '0;
      sext       <= 1'b0;
      wdat       <= '0;
      res        <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_dout   <= '0;
      done       <= '0;
      rdata      <= '0;
    end else begin
      done   <= '0;
      ram_we <= 1'b0;
      case (state)
        IDLE: if (sel_vld) begin
          gnt        <= sel;
          last_grant <= sel;
          la         <= sel_addr;
          len        <= sel_len;
          sext       <= req_sext[sel];
          wdat       <= req_wdata[int'(sel)*32 +: 32];
          cnt        <= '0;
          res        <= '0;
          ram_addr   <= sel_addr;  // first read address goes out on accept
        end
        RD: begin
          if (state_nx == RD) begin
            cnt <= cnt + 3'd1;
            if (cnt < len - 3'd1) ram_addr <= la + ADDR_W'(cnt + 3'd1);
            // byte driven at edge k lands two edges later
            case (cnt)
              3'd1:    res[7:0]   <= ram_din;
              3'd2:    res[15:8]  <= ram_din;
              3'd3:    res[23:16] <= ram_din;
              default: ;
            endcase
          end else if (cnt == len) begin
            rdata     <= rd_ext;
            done[gnt] <= 1'b1;
          end
        end
        WR: begin
          if (cnt < len) begin
            ram_we   <= 1'b1;
            ram_addr <= la + ADDR_W'(cnt);
            ram_dout <= wdat[int'(cnt[1:0])*8 +: 8];
            cnt      <= cnt + 3'd1;
          end else begin
            done[gnt] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
